uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the UART receiver. It captures each received word on the receiver's one-cycle done pulse and queues it for a host/bus reader. Storage is a circular buffer with first-word-fall-through output. It tracks occupancy and raises a sticky overflow flag when a word arrives while the buffer is full.

Parameters:
DBITS, 8, data word width; must match the receiver's data width.
ADDR_WIDTH, 4, pointer width; depth = 2**ADDR_WIDTH entries (default 16).

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
rx_done_tick  input  1  one-cycle pulse from the receiver; each high cycle is one write request.
rx_dout  input  DBITS  received word; sampled in the same cycle as rx_done_tick.
rd_uart  input  1  read/pop request from the consumer.
clr_overflow  input  1  clears the sticky overflow flag.
r_data  output  DBITS  head-of-queue word; FWFT, valid whenever rx_empty=0.
rx_empty  output  1  high when count=0.
rx_full  output  1  high when count=2**ADDR_WIDTH.
count  output  ADDR_WIDTH+1  number of stored words, 0..2**ADDR_WIDTH.
overflow  output  1  sticky flag: at least one word was dropped because the buffer was full.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset, sampled only at the rising edge of clk.
- Reset, and reset asserted mid-operation, produce:
  - wr_ptr=0, rd_ptr=0, count=0, rx_empty=1, rx_full=0, overflow=0.
  - Storage array contents are not reset.
  - Reset has priority over all other inputs in that cycle.
- Pointers are ADDR_WIDTH bits and wrap modulo depth: all-ones +1 gives 0. No special case for non-power-of-2 depth.
- Write: rx_done_tick=1 and (rx_full=0, or a read is accepted in the same cycle) gives:
  - mem[wr_ptr] <= rx_dout;
  - wr_ptr+1.
- Read accepted: rd_uart=1 and rx_empty=0 gives rd_ptr+1. rd_uart while empty is ignored; no pointer or flag change.
- r_data = mem[rd_ptr], combinational from the array, so it is FWFT.
  - The first written word appears on r_data the cycle after the write edge, when rx_empty falls.
  - r_data is don't-care while rx_empty=1.
- Write-to-read latency: 1 cycle (rx_empty deasserts one cycle after the rx_done_tick cycle).
- Count update per cycle:
  - write only: +1;
  - read only: -1;
  - both accepted: unchanged;
  - neither: unchanged.
- rx_empty and rx_full are registered and derived from the next count. They are never both high.
- Simultaneous events:
  - Full + write + read: both accepted. The oldest word is popped, the new word is stored, count stays at depth, overflow is not set.
  - Empty + write + read: read ignored, write accepted, count becomes 1.
- Overflow: rx_done_tick=1, rx_full=1 and no accepted read gives:
  - word dropped;
  - pointers and count unchanged;
  - overflow <= 1.
- overflow stays high until clr_overflow=1. If a new overflow event and clr_overflow occur in the same cycle, set wins (overflow stays 1).
- No internal state machine beyond the pointer/count registers. All outputs except r_data are registered.

Test Plan:
1. Reset, then push 8'hA5 (one rx_done_tick) -> next cycle rx_empty=0, count=1, r_data=8'hA5. Pop -> next cycle rx_empty=1, count=0.
2. Push 16 words 8'h00..8'h0F -> rx_full=1, count=16. Pop 16 -> r_data sequence 8'h00..8'h0F in order, then rx_empty=1. Push/pop 20 more to cross the pointer wrap -> order preserved.
3. When full, push 8'hFF with no read -> overflow=1, count=16, 8'hFF never read out. Assert clr_overflow -> overflow=0 next cycle.
4. When full, rx_done_tick with 8'h55 and rd_uart in the same cycle -> head popped, count stays 16, overflow=0, 8'h55 read out last.
5. When empty, rd_uart and rx_done_tick with 8'h3C together -> count=1, r_data=8'h3C. rd_uart alone while empty -> no change.
6. With count=5 and overflow=1, assert reset for one cycle -> count=0, rx_empty=1, rx_full=0, overflow=0. Subsequent push of 8'h12 reads back 8'h12.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT circular receive buffer with occupancy count and sticky overflow
module uart_rx_fifo #(
    parameter int DBITS      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_done_tick,
    input  logic [DBITS-1:0]      rx_dout,
    input  logic                  rd_uart,
    input  logic                  clr_overflow,
    output logic [DBITS-1:0]      r_data,
    output logic                  rx_empty,
    output logic                  rx_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DBITS-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  rd_ok, wr_ok;

    assign rd_ok  = rd_uart & ~rx_empty;
    assign wr_ok  = rx_done_tick & (~rx_full | rd_ok);
    assign r_data = mem[rd_ptr];

    // next occupancy: a simultaneous accepted read and write cancel out
    always_comb begin
        count_next = (wr_ok & ~rd_ok) ? count + (ADDR_WIDTH+1)'(1) :
                     (rd_ok & ~wr_ok) ? count - (ADDR_WIDTH+1)'(1) : count;
    end

    // storage is never cleared; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) mem[wr_ptr] <= rx_dout;
    end

    // pointers, registered flags and sticky overflow (set beats clear)
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rx_empty <= 1'b1;
            rx_full  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ok ? wr_ptr + ADDR_WIDTH'(1) : wr_ptr;
            rd_ptr   <= rd_ok ? rd_ptr + ADDR_WIDTH'(1) : rd_ptr;
            count    <= count_next;
            rx_empty <= count_next == '0;
            rx_full  <= count_next == (ADDR_WIDTH+1)'(DEPTH);
            overflow <= (rx_done_tick & rx_full & ~rd_ok) ? 1'b1 :
                        clr_overflow ? 1'b0 : overflow;
        end
    end
endmodule
